adder_rr_sched: RTL and testbench
=================================

Name: adder_rr_sched

Overview:
Round-robin scheduler that shares one registered 4-bit add-with-carry datapath among NREQ requesters. Each requester presents operands over a valid/ready handshake. The scheduler grants one requester per cycle and computes {cout,sum} = a + b + cin in one registered stage. It returns the result, tagged with the requester index, over a backpressured response port. It sits between client blocks and the shared adder resource.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ
CNTW, 16, width of the completed-operation counter

Ports:
iClk  in  1  clock
iRstN  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_a  in  4*NREQ  operand a; requester i uses bits [4i+3:4i]
req_b  in  4*NREQ  operand b; same packing as req_a
req_cin  in  NREQ  carry-in per requester
req_ready  out  NREQ  one-hot grant; a handshake completes when req_valid[i] & req_ready[i]
rsp_valid  out  1  result valid
rsp_sum  out  4  sum bits
rsp_cout  out  1  carry-out
rsp_id  out  IDW  index of the requester that issued the result
rsp_ready  in  1  consumer accepts the result
op_count  out  CNTW  number of accepted responses, wraps modulo 2**CNTW

Behaviour:
- Reset (iRstN=0 at a posedge) clears rsp_valid, rsp_sum, rsp_cout, rsp_id and op_count to 0. It also sets the round-robin pointer ptr to 0, giving requester 0 highest priority.
- Reset mid-operation discards any pending result. No response is emitted for a request granted in the reset cycle.
- req_ready is forced to 0 while iRstN=0.
- slot_free = ~rsp_valid | rsp_ready.
- Grant (combinational):
  - If slot_free, req_ready = one-hot of the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - Otherwise req_ready = 0.
  - req_ready[i]=1 is never asserted while req_valid[i]=0.
  - req_ready may depend combinationally on req_valid and rsp_ready. It must not depend on req_a, req_b or req_cin.
- Issue: when a grant to requester g occurs at posedge t:
  - rsp_valid=1 from t+1 (latency 1 cycle).
  - {rsp_cout,rsp_sum} = a_g + b_g + cin_g, computed at 5-bit width. Example: 15+15+1 gives cout=1, sum=15.
  - rsp_id = g.
  - ptr becomes (g+1) mod NREQ.
- No grant at a posedge leaves ptr unchanged.
- Response hold: while rsp_valid & ~rsp_ready, rsp_valid, rsp_sum, rsp_cout and rsp_id hold stable and no grant is issued.
- Drain-and-refill: if rsp_valid & rsp_ready and a new grant occurs in the same cycle, the response registers load the new result. rsp_valid stays 1, giving back-to-back throughput of 1 op/cycle.
- Drain without refill: rsp_valid & rsp_ready with no grant makes rsp_valid 0 next cycle.
- op_count increments by 1 on each posedge where rsp_valid & rsp_ready, and wraps from 2**CNTW-1 to 0.
- Requesters must hold req_a, req_b and req_cin stable while req_valid=1 and not granted. A requester may deassert req_valid without penalty.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 grants of others.
- Out-of-range ptr values are unreachable. The pointer logic must still wrap modulo NREQ for non-power-of-two NREQ.

Test Plan:
- Reset then single request: hold reset 2 cycles; req0 a=3,b=4,cin=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, sum=8, cout=0, id=0; op_count=1 after the rsp_ready handshake.
- Overflow: req2 a=15,b=15,cin=1 -> rsp sum=15, cout=1, id=2. Then a=8,b=8,cin=0 -> sum=0, cout=1.
- Round-robin, all 4 valid, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3. rsp_valid stays 1 continuously from the 2nd cycle; op_count=8 after the last response drains.
- Backpressure: result pending with rsp_ready=0 for 3 cycles while req1 and req3 are valid -> req_ready=0000 and response fields stable for those 3 cycles. When rsp_ready=1, req1 is granted in the same cycle and its result appears next cycle.
- Pointer fairness: grant req3 (ptr wraps to 0), then req0 and req3 both valid -> req0 granted. Then req3 and req0 valid again -> req3 granted (ptr=1).
- Reset mid-operation: assert iRstN=0 in the cycle a grant occurs with rsp_valid=1 pending -> next cycle rsp_valid=0, op_count=0, ptr=0; no stale response appears after reset releases.

Source files
------------

// File: rtl/adder_rr_sched_if.sv
// Request/response bundle between client blocks and the shared add-with-carry scheduler.
// Operands for requester i sit in bits [4i+3:4i] of req_a/req_b.
interface adder_rr_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_cin;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [3:0]        rsp_sum;
   logic              rsp_cout;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_ready;

   // Client side: issues requests and consumes responses.
   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
   );
endinterface

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered 4-bit add-with-carry stage among NREQ requesters.
// One grant per cycle; result returned tagged with the requester index over a backpressured port.
module adder_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              iClk,
   input  logic              iRstN,
   adder_rr_sched_if.slave   bus,
   output logic [CNTW-1:0]   op_count
);

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   slot_state_t     slot_state_reg;
   slot_state_t     slot_state_next;

   logic [3:0]      rsp_sum_reg;
   logic [3:0]      rsp_sum_next;
   logic            rsp_cout_reg;
   logic            rsp_cout_next;
   logic [IDW-1:0]  rsp_id_reg;
   logic [IDW-1:0]  rsp_id_next;
   logic [IDW-1:0]  ptr_reg;
   logic [IDW-1:0]  ptr_next;
   logic [CNTW-1:0] op_count_reg;
   logic [CNTW-1:0] op_count_next;

   logic [3:0]      op_a   [NREQ];
   logic [3:0]      op_b   [NREQ];
   logic            op_cin [NREQ];

   logic            rsp_valid;
   logic            slot_free;
   logic            rsp_accept;
   logic            gnt_found;
   logic [IDW-1:0]  gnt_idx;
   logic            issue;
   logic [NREQ-1:0] grant_oh;
   logic [4:0]      sum5;

   // Unpack the flat operand buses into per-requester lanes.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
         assign op_a[gi]   = bus.req_a[4*gi +: 4];
         assign op_b[gi]   = bus.req_b[4*gi +: 4];
         assign op_cin[gi] = bus.req_cin[gi];
      end
   endgenerate

   assign rsp_valid  = (slot_state_reg == SLOT_FULL);
   assign slot_free  = ~rsp_valid | bus.rsp_ready;
   assign rsp_accept = rsp_valid & bus.rsp_ready;

   // Rotating-priority search starting at ptr; depends only on req_valid and ptr.
   always_comb begin : grant_search
      logic [IDW:0] cand;
      cand      = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   assign issue = gnt_found & slot_free & iRstN;

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (issue && (gnt_idx == IDW'(i))) begin
            grant_oh[i] = 1'b1;
         end
      end
   end

   assign bus.req_ready = grant_oh;

   // The single shared adder stage, fed by the granted lane.
   assign sum5 = {1'b0, op_a[gnt_idx]} + {1'b0, op_b[gnt_idx]} + {4'b0000, op_cin[gnt_idx]};

   // Response slot FSM plus datapath/pointer next-state.
   always_comb begin
      slot_state_next = slot_state_reg;
      rsp_sum_next    = rsp_sum_reg;
      rsp_cout_next   = rsp_cout_reg;
      rsp_id_next     = rsp_id_reg;
      ptr_next        = ptr_reg;
      op_count_next   = op_count_reg;

      case (slot_state_reg)
         SLOT_EMPTY: begin
            if (issue) begin
               slot_state_next = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (bus.rsp_ready && !issue) begin
               slot_state_next = SLOT_EMPTY;
            end
         end
         default: slot_state_next = SLOT_EMPTY;
      endcase

      if (issue) begin
         rsp_sum_next  = sum5[3:0];
         rsp_cout_next = sum5[4];
         rsp_id_next   = gnt_idx;
         // Explicit wrap keeps the pointer in range for non-power-of-two NREQ.
         if (gnt_idx == IDW'(NREQ-1)) begin
            ptr_next = '0;
         end else begin
            ptr_next = gnt_idx + 1'b1;
         end
      end

      if (rsp_accept) begin
         op_count_next = op_count_reg + 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         slot_state_reg <= SLOT_EMPTY;
         rsp_sum_reg    <= '0;
         rsp_cout_reg   <= 1'b0;
         rsp_id_reg     <= '0;
         ptr_reg        <= '0;
         op_count_reg   <= '0;
      end else begin
         slot_state_reg <= slot_state_next;
         rsp_sum_reg    <= rsp_sum_next;
         rsp_cout_reg   <= rsp_cout_next;
         rsp_id_reg     <= rsp_id_next;
         ptr_reg        <= ptr_next;
         op_count_reg   <= op_count_next;
      end
   end

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_sum   = rsp_sum_reg;
   assign bus.rsp_cout  = rsp_cout_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign op_count      = op_count_reg;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: stimulus pushes expected results, a monitor pops and compares.
// A narrow op_count lets the counter wrap within a short run.
module tb_adder_rr_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 4;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           cout;
      logic [3:0]     sum;
   } rsp_t;

   logic            clk  = 1'b0;
   logic            rstn = 1'b0;
   logic [CNTW-1:0] op_count;

   rsp_t exp_q[$];
   rsp_t exp_item;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   adder_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   adder_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .iClk     (clk),
      .iRstN    (rstn),
      .bus      (bus),
      .op_count (op_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic cin);
      bus.req_a[4*i +: 4] = a;
      bus.req_b[4*i +: 4] = b;
      bus.req_cin[i]      = cin;
   endtask

   // One cycle: check the grant mid-cycle, queue the expected result if a grant is due.
   task automatic step(input logic [NREQ-1:0] exp_ready, input bit push,
                       input logic [3:0] exp_sum, input logic exp_cout, input bit chk_rv);
      logic [IDW-1:0] id;
      id = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (exp_ready[i]) id = IDW'(i);
      end
      @(negedge clk);
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (chk_rv) check("rsp_valid_cont", 32'(bus.rsp_valid), 32'd1);
      if (push) exp_q.push_back('{id: id, cout: exp_cout, sum: exp_sum});
      @(posedge clk);
      #1;
   endtask

   // Idle cycle that drains the last response, then check the counter.
   task automatic drain_and_count(input logic [CNTW-1:0] exp_cnt);
      step('0, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("op_count", 32'(op_count), 32'(exp_cnt));
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rstn && bus.rsp_valid && bus.rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected: got id=%0d cout=%0d sum=%0d required none",
                     bus.rsp_id, bus.rsp_cout, bus.rsp_sum);
         end else begin
            exp_item = exp_q.pop_front();
            if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== exp_item) begin
               failures++;
               $display("FAIL rsp: got id=%0d cout=%0d sum=%0d required id=%0d cout=%0d sum=%0d",
                        bus.rsp_id, bus.rsp_cout, bus.rsp_sum, exp_item.id, exp_item.cout, exp_item.sum);
            end else begin
               $display("ok   rsp: id=%0d cout=%0d sum=%0d", bus.rsp_id, bus.rsp_cout, bus.rsp_sum);
            end
         end
      end
   end

   initial begin
      #200000;
      checks++;
      failures++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [3:0] rr_sum  [NREQ];
      logic       rr_cout [NREQ];

      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = '0;
      bus.rsp_ready = 1'b0;

      // Reset: grants suppressed even with every requester valid.
      repeat (2) begin
         @(negedge clk);
         check("req_ready_in_reset", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      rstn          = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_fields", 32'({bus.rsp_id, bus.rsp_cout, bus.rsp_sum}), 32'd0);
      check("reset_op_count", 32'(op_count), 32'd0);
      @(posedge clk);
      #1;

      // Single request: 3+4+1 = 8.
      set_req(0, 4'd3, 4'd4, 1'b1);
      bus.req_valid = 4'b0001;
      step(4'b0001, 1'b1, 4'd8, 1'b0, 1'b0);
      bus.req_valid = '0;
      drain_and_count(4'd1);

      // Overflow cases on requester 2.
      set_req(2, 4'd15, 4'd15, 1'b1);
      bus.req_valid = 4'b0100;
      step(4'b0100, 1'b1, 4'd15, 1'b1, 1'b0);
      set_req(2, 4'd8, 4'd8, 1'b0);
      step(4'b0100, 1'b1, 4'd0, 1'b1, 1'b0);
      bus.req_valid = '0;
      drain_and_count(4'd3);

      // Pointer fairness: ptr=3 -> req3, wrap -> req0, then ptr=1 -> req3.
      set_req(0, 4'd1, 4'd2, 1'b0);
      set_req(3, 4'd10, 4'd3, 1'b1);
      bus.req_valid = 4'b1001;
      step(4'b1000, 1'b1, 4'd14, 1'b0, 1'b0);
      step(4'b0001, 1'b1, 4'd3, 1'b0, 1'b0);
      step(4'b1000, 1'b1, 4'd14, 1'b0, 1'b0);

      // Round-robin, all valid, ptr back at 0.
      set_req(1, 4'd5, 4'd6, 1'b1);
      set_req(2, 4'd9, 4'd7, 1'b0);
      rr_sum[0] = 4'd3;  rr_cout[0] = 1'b0;
      rr_sum[1] = 4'd12; rr_cout[1] = 1'b0;
      rr_sum[2] = 4'd0;  rr_cout[2] = 1'b1;
      rr_sum[3] = 4'd14; rr_cout[3] = 1'b0;
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step(NREQ'(1 << (k % NREQ)), 1'b1, rr_sum[k % NREQ], rr_cout[k % NREQ], k >= 1);
      end
      bus.req_valid = '0;
      drain_and_count(4'd14);

      // Backpressure: pending result holds, no grants, then drain-and-refill.
      bus.req_valid = 4'b0001;
      step(4'b0001, 1'b1, 4'd3, 1'b0, 1'b0);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1010;
      repeat (3) begin
         @(negedge clk);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_rsp_hold", 32'({bus.rsp_id, bus.rsp_cout, bus.rsp_sum}), 32'({2'd0, 1'b0, 4'd3}));
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      step(4'b0010, 1'b1, 4'd12, 1'b0, 1'b1);
      bus.req_valid = '0;
      drain_and_count(4'd0);

      // Reset in the cycle a grant would occur, with a result pending.
      bus.req_valid = 4'b0100;
      step(4'b0100, 1'b1, 4'd0, 1'b1, 1'b0);
      rstn          = 1'b0;
      bus.req_valid = 4'b1000;
      step(4'b0000, 1'b0, 4'd0, 1'b0, 1'b1);
      rstn          = 1'b1;
      exp_q.delete();
      bus.req_valid = '0;
      @(negedge clk);
      check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midreset_op_count", 32'(op_count), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 4'b1111;
      step(4'b0001, 1'b1, 4'd3, 1'b0, 1'b0);
      bus.req_valid = '0;
      drain_and_count(4'd1);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
